part_74s157_demux: RTL

Clocked receive-side companion to the quad 2:1 data selector: it samples a 4-bit bus time-multiplexed by a selector (word A when SEL=0, word B when SEL=1, outputs gated by ENB_N) and rebuilds the two 4-bit words as one registered 8-bit pair. Completed pairs go to a consumer through a valid/ready handshake. Protocol errors and drops are counted. It sits on the far side of any selector-multiplexed nibble path in the board model.

---
 rtl/part_74s157_demux.sv | 77 +++++++
 1 files changed

// File: rtl/part_74s157_demux.sv
// rtl/part_74s157_demux.sv - rebuilds A/B nibble pairs from a selector-multiplexed bus
module part_74s157_demux (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] D,
   input  logic       SEL,
   input  logic       ENB_N,
   output logic [3:0] QA,
   output logic [3:0] QB,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [3:0] sync_err,
   output logic [3:0] ovf_cnt
);

   typedef enum logic {IDLE, GOT_A} state_t;

   state_t     state;
   logic [3:0] sa;

   logic a_evt;
   logic b_evt;
   logic complete;
   logic slot_free;
   logic order_err;

   // Decode strobe/tag into word events and the pair-completion conditions
   always_comb begin
      a_evt     = !ENB_N && !SEL;
      b_evt     = !ENB_N && SEL;
      complete  = (state == GOT_A) && b_evt;
      slot_free = !out_valid || out_ready;
      order_err = ((state == IDLE) && b_evt) || ((state == GOT_A) && a_evt);
   end

   // Pairing FSM, output slot and saturating error counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         sa        <= 4'h0;
         QA        <= 4'h0;
         QB        <= 4'h0;
         out_valid <= 1'b0;
         sync_err  <= 4'h0;
         ovf_cnt   <= 4'h0;
      end else begin
         // A newer A word always replaces the staged one
         if (a_evt) begin
            sa <= D;
         end

         case (state)
            IDLE:    if (a_evt) state <= GOT_A;
            GOT_A:   if (b_evt) state <= IDLE;
            default: state <= IDLE;
         endcase

         // A completing pair wins over a plain consume, so no bubble appears
         if (complete && slot_free) begin
            QA        <= sa;
            QB        <= D;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (complete && !slot_free && (ovf_cnt != 4'hF)) begin
            ovf_cnt <= ovf_cnt + 4'h1;
         end

         if (order_err && (sync_err != 4'hF)) begin
            sync_err <= sync_err + 4'h1;
         end
      end
   end

endmodule
